// File: rtl/clock_divider.sv
// Divides clk by system_freq/required_freq with a 50% duty output; odd ratios combine
// a rising-edge register with a falling-edge copy to gain the extra half period.
module clock_divider #(
   parameter int unsigned system_freq   = 100_000_000,
   parameter int unsigned required_freq = 50_000
) (
   input  logic clk,
   input  logic reset,
   output logic out
);

   localparam int unsigned Div  = system_freq / required_freq;
   localparam int unsigned CntW = $clog2(Div) + 1;

   localparam logic [CntW-1:0] CntOne = CntW'(1);

   generate
      if (Div < 2) begin : gen_bad_ratio
         $fatal(1, "clock_divider: system_freq=%0d required_freq=%0d gives divide ratio below 2",
                system_freq, required_freq);
         assign out = 1'b0;
      end else if (Div % 2 == 0) begin : gen_even
         localparam logic [CntW-1:0] CntLast = CntW'(Div / 2 - 1);

         logic [CntW-1:0] cnt_q, cnt_d;
         logic            tgl_q, tgl_d;

         always_comb begin
            cnt_d = cnt_q + CntOne;
            tgl_d = tgl_q;
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               tgl_d = ~tgl_q;
            end
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q <= '0;
               tgl_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               tgl_q <= tgl_d;
            end
         end

         assign out = tgl_q;
      end else begin : gen_odd
         localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
         localparam logic [CntW-1:0] PHigh   = CntW'((Div - 1) / 2);

         logic [CntW-1:0] cnt_q, cnt_d;
         logic            p_q, p_d;
         logic            n_q;

         always_comb begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntOne;
            // p is high for (Div-1)/2 full cycles; n stretches it by half a cycle
            p_d   = (cnt_q < PHigh);
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q <= '0;
               p_q   <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               p_q   <= p_d;
            end
         end

         always_ff @(negedge clk or negedge reset) begin
            if (!reset) begin
               n_q <= 1'b0;
            end else begin
               n_q <= p_q;
            end
         end

         assign out = p_q | n_q;
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: several ratios side by side, compared every half clk period
// against an arithmetic model of the expected waveform.
module tb_clock_divider;

   localparam int NDut = 6;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NDut-1:0] outs;

   int unsigned divs [NDut] = '{2000, 2, 5, 3, 4, 7};

   int          errors = 0;
   int          checks = 0;
   int unsigned k = 0;

   always #5 clk = ~clk;

   clock_divider u_div2000 (.clk(clk), .reset(reset), .out(outs[0]));
   clock_divider #(.system_freq(100_000_000), .required_freq(50_000_000))
      u_div2 (.clk(clk), .reset(reset), .out(outs[1]));
   clock_divider #(.system_freq(100_000_000), .required_freq(20_000_000))
      u_div5 (.clk(clk), .reset(reset), .out(outs[2]));
   clock_divider #(.system_freq(100_000_000), .required_freq(30_000_000))
      u_div3 (.clk(clk), .reset(reset), .out(outs[3]));
   clock_divider #(.system_freq(100_000_000), .required_freq(25_000_000))
      u_div4 (.clk(clk), .reset(reset), .out(outs[4]));
   clock_divider #(.system_freq(70_000_000), .required_freq(10_000_000))
      u_div7 (.clk(clk), .reset(reset), .out(outs[5]));

   // Expected out after k rising edges since release (neg: sampled after the following fall).
   function automatic logic model_out(int unsigned div, int unsigned kk, bit neg);
      int unsigned h;
      if (kk == 0) return 1'b0;
      if (div % 2 == 0) return ((kk / (div / 2)) % 2) == 1;
      h = 2 * (kk - 1) + (neg ? 1 : 0);
      return (h % (2 * div)) < div;
   endfunction

   task automatic release_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      k     = 0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL reset_hold_pos: outs=%b expected=%b", outs, {NDut{1'b0}});
         end
         @(negedge clk);
         #1;
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL reset_hold_neg: outs=%b expected=%b", outs, {NDut{1'b0}});
         end
      end
      release_reset();
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_release: outs=%b expected=%b", outs, {NDut{1'b0}});
      end
   endtask

   task automatic test_startup_waveform();
      int unsigned rise_edge = 0;
      for (int c = 0; c < 4500; c++) begin
         @(posedge clk);
         k++;
         #1;
         if (outs[0] && rise_edge == 0) rise_edge = k;
         for (int i = 0; i < NDut; i++) begin
            checks++;
            if (outs[i] !== model_out(divs[i], k, 1'b0)) begin
               errors++;
               $display("FAIL startup_pos div=%0d edge=%0d: out=%b expected=%b",
                        divs[i], k, outs[i], model_out(divs[i], k, 1'b0));
            end
         end
         @(negedge clk);
         #1;
         for (int i = 0; i < NDut; i++) begin
            checks++;
            if (outs[i] !== model_out(divs[i], k, 1'b1)) begin
               errors++;
               $display("FAIL startup_neg div=%0d edge=%0d: out=%b expected=%b",
                        divs[i], k, outs[i], model_out(divs[i], k, 1'b1));
            end
         end
      end
      checks++;
      if (rise_edge !== 1000) begin
         errors++;
         $display("FAIL first_rise_div2000: edge=%0d expected=%0d", rise_edge, 1000);
      end
   endtask

   task automatic test_async_reset();
      int unsigned rise_edge = 0;
      // Restart cleanly, then run 5 us into the first high phase of the default divider.
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL async_assert_idle: outs=%b expected=%b", outs, {NDut{1'b0}});
      end
      #100;
      release_reset();
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         k++;
      end
      #1;
      checks++;
      if (outs[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_high_before_reset: out=%b expected=%b", outs[0], 1'b1);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL async_assert_mid_high: outs=%b expected=%b", outs, {NDut{1'b0}});
      end
      #100;
      release_reset();
      for (int c = 0; c < 1200; c++) begin
         @(posedge clk);
         k++;
         #1;
         if (outs[0] && rise_edge == 0) rise_edge = k;
         for (int i = 0; i < NDut; i++) begin
            checks++;
            if (outs[i] !== model_out(divs[i], k, 1'b0)) begin
               errors++;
               $display("FAIL restart_pos div=%0d edge=%0d: out=%b expected=%b",
                        divs[i], k, outs[i], model_out(divs[i], k, 1'b0));
            end
         end
         @(negedge clk);
         #1;
         for (int i = 0; i < NDut; i++) begin
            checks++;
            if (outs[i] !== model_out(divs[i], k, 1'b1)) begin
               errors++;
               $display("FAIL restart_neg div=%0d edge=%0d: out=%b expected=%b",
                        divs[i], k, outs[i], model_out(divs[i], k, 1'b1));
            end
         end
      end
      checks++;
      if (rise_edge !== 1000) begin
         errors++;
         $display("FAIL restart_rise_div2000: edge=%0d expected=%0d", rise_edge, 1000);
      end
   endtask

   task automatic test_random_reset();
      int unsigned run_len;
      int unsigned hold;
      for (int it = 0; it < 12; it++) begin
         run_len = $urandom_range(1, 300);
         for (int c = 0; c < int'(run_len); c++) begin
            @(posedge clk);
            k++;
            #1;
            for (int i = 0; i < NDut; i++) begin
               checks++;
               if (outs[i] !== model_out(divs[i], k, 1'b0)) begin
                  errors++;
                  $display("FAIL random_pos it=%0d div=%0d edge=%0d: out=%b expected=%b",
                           it, divs[i], k, outs[i], model_out(divs[i], k, 1'b0));
               end
            end
            @(negedge clk);
            #1;
            for (int i = 0; i < NDut; i++) begin
               checks++;
               if (outs[i] !== model_out(divs[i], k, 1'b1)) begin
                  errors++;
                  $display("FAIL random_neg it=%0d div=%0d edge=%0d: out=%b expected=%b",
                           it, divs[i], k, outs[i], model_out(divs[i], k, 1'b1));
               end
            end
         end
         // Assert between edges and confirm the clear happens with no clk edge.
         @(posedge clk);
         k++;
         #($urandom_range(2, 3));
         reset = 1'b0;
         #1;
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL random_async_assert it=%0d: outs=%b expected=%b",
                     it, outs, {NDut{1'b0}});
         end
         hold = $urandom_range(1, 8);
         for (int c = 0; c < int'(hold); c++) @(posedge clk);
         #1;
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL random_reset_hold it=%0d: outs=%b expected=%b",
                     it, outs, {NDut{1'b0}});
         end
         release_reset();
      end
   endtask

   initial begin
      test_reset();
      test_startup_waveform();
      test_async_reset();
      test_random_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter system_freq, default 100_000_000; input clock frequency in Hz, positive integer.
REQ-002 Parameter required_freq, default 50_000; target output frequency in Hz, positive integer.
REQ-003 Port clk  input  1  system clock; all sequential logic uses it (rising edge, plus falling edge only per REQ-012).
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port out  output  1  divided clock.

Function
REQ-006 Divide ratio DIV SHALL be system_freq/required_freq, integer division truncating toward zero.
- Example: 100M/30M gives DIV=3.
REQ-007 If DIV < 2, elaboration SHALL fail with a fatal message naming both parameter values.
REQ-008 Internal counter width SHALL be $clog2(DIV)+1 bits, computed from the parameters.
- No fixed-width counter; no overflow for any legal DIV.
REQ-009 out period SHALL be exactly DIV clk periods, for all legal DIV.
REQ-010 Even DIV: the rising-edge counter SHALL count 0..DIV/2-1, wrap to 0, and toggle out on each wrap.
- Result: high DIV/2 cycles, low DIV/2 cycles.
REQ-011 Odd DIV: a rising-edge counter SHALL count 0..DIV-1 and wrap to 0.
- Register p = 1 while counter < (DIV-1)/2, else 0.
REQ-012 Odd DIV: register n SHALL capture p on the falling edge of clk.
- out = p OR n.
- Result: high DIV/2 periods, low DIV/2 periods (exactly 50% duty).
REQ-013 out SHALL be driven only from registers, or from the OR of two registers in the odd case.
- No other combinational path from clk to out.
REQ-014 After reset release, out SHALL stay 0 for the first low phase.
- Even DIV: first rise on the DIV/2-th rising clk edge after release.
- Odd DIV: first rise follows the first rising clk edge after release.
REQ-015 Counter and out SHALL run continuously with no dead cycles at wrap-around.
REQ-016 Duty cycle SHALL be 50% for every legal DIV, within half a clk period.

Reset
REQ-017 While reset=0, counter, p, n and the toggle register SHALL be 0, so out=0, independent of clk.
REQ-018 Assertion of reset SHALL force out to 0 immediately (asynchronously), including mid-high phase.
REQ-019 After release, the sequence SHALL restart from count 0 identically to the first start-up.

Verification
REQ-020 Defaults (clk 10 ns period, DIV=2000), reset low for 20 ns then high:
- out = 0 for 1000 rising edges (10 us after release), then rises.
- High 10 us, low 10 us; period 20 us.
REQ-021 system_freq=100M, required_freq=50M (DIV=2): out toggles every rising edge.
- out period 20 ns, high 10 ns.
REQ-022 system_freq=100M, required_freq=20M (DIV=5): out period 50 ns.
- High 25 ns, low 25 ns; edges alternate between clk rising and falling edges.
REQ-023 system_freq=100M, required_freq=30M (DIV=3): out period 30 ns, high 15 ns.
REQ-024 Defaults, reset pulled low 5 us into the first high phase, released 100 ns later:
- out drops to 0 at the reset assertion, without waiting for a clk edge.
- out rises again exactly 1000 rising edges after release.
REQ-025 required_freq > system_freq (DIV=0): elaboration fails.
